// File: rtl/gol_pkg.sv
// Shared command, direction and auto-repeat state types for the Game of Life
// viewer window/cursor controller.
package gol_pkg;

  typedef struct packed {
    logic move_up;
    logic move_down;
    logic move_left;
    logic move_right;
    logic move_mode;   // 0 = cursor, 1 = window
    logic zoom_in;
    logic zoom_out;
  } WC_CMDS;

  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} DIR_E;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} REP_STATE_E;

  function automatic logic [2:0] n_held(input logic [3:0] d);
    return 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
  endfunction

endpackage

// File: rtl/auto_repeat.sv
// Turns held direction levels into step pulses: one on press, one after
// REPEAT_DLY ticks, then one every REPEAT_PER ticks while the same button stays held.
module auto_repeat
  import gol_pkg::*;
#(
  parameter int REPEAT_DLY = 16,
  parameter int REPEAT_PER = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       i_tick,
  input  logic [3:0] i_dirs,       // {up, down, left, right}
  output logic [3:0] o_step,
  output logic       o_err_multi
);

  localparam int CMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  REP_STATE_E    r_state, w_state_nxt;
  DIR_E          r_dir, w_dir, w_dir_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err;
  logic          w_fire;

  // NONE covers both "nothing held" and "several held"
  always_comb begin
    case (i_dirs)
      4'b1000: w_dir = UP;
      4'b0100: w_dir = DOWN;
      4'b0010: w_dir = LEFT;
      4'b0001: w_dir = RIGHT;
      default: w_dir = NONE;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    if (w_dir == NONE || (r_state != IDLE && w_dir != r_dir)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_fire      = 1'b1;
          w_dir_nxt   = w_dir;
          w_cnt_nxt   = '0;
          w_state_nxt = DELAY;
        end
        DELAY, REPEAT: begin
          if (i_tick) begin
            if (r_cnt == ((r_state == DELAY) ? DLY_LAST : PER_LAST)) begin
              w_fire      = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_dir   <= NONE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= (n_held(i_dirs) > 3'd1);
    end
  end

  assign o_step      = w_fire ? i_dirs : 4'b0000;
  assign o_err_multi = r_err;

endmodule

// File: rtl/win_curs_ctrl.sv
// Window/cursor/zoom controller for the Game of Life viewer.
// Define WC_WRAP_EN for a toroidal board (window wraps, no clamping).
module win_curs_ctrl
  import gol_pkg::*;
#(
  parameter int K          = 7,
  parameter int ZW         = 3,
  parameter int ZMIN       = 2,
  parameter int ZMAX       = 6,
  parameter int INIT_ZOOM  = 4,
  parameter int REPEAT_DLY = 16,
  parameter int REPEAT_PER = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          tick,
  input  logic          run_mode,
  input  WC_CMDS        wc_cmds,
  output logic [ZW-1:0] zoom_lvl,
  output logic [K:0]    win_numCells,
  output logic [K-1:0]  winR,
  output logic [K-1:0]  winC,
  output logic [K-1:0]  cursR,
  output logic [K-1:0]  cursC,
  output logic [K-1:0]  abs_cursR,
  output logic [K-1:0]  abs_cursC,
  output logic          err_multi
);

`ifdef WC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [K:0]   B_L      = (K+1)'(1) << K;
  localparam logic [K-1:0] CURS_RST = K'((1 << INIT_ZOOM) / 2);

  logic [ZW-1:0]  r_zoom;
  logic [K-1:0]   r_winR, r_winC, r_cursR, r_cursC;
  logic           r_run_q;
  logic [3:0]     w_step;
  logic [K:0]     w_n, w_n2;
  logic [K-1:0]   w_half, w_absR, w_absC;
  logic           w_zin, w_zout, w_run_rise, w_cur_mode;
  logic [2*K-1:0] w_stepR, w_stepC, w_zoomR, w_zoomC;

  // One axis of a step; returns {win, curs}. neg/pos select the direction.
  function automatic logic [2*K-1:0] f_step(
    input logic [K-1:0] win,
    input logic [K-1:0] curs,
    input logic [K:0]   n,
    input logic         neg,
    input logic         pos,
    input logic         cur_mode
  );
    logic [K:0]   lo, hi, c_ext, w_end;
    logic [K-1:0] w, c;
    logic         can_dec, can_inc;
    w       = win;
    c       = curs;
    c_ext   = {1'b0, curs};
    w_end   = {1'b0, win} + n;
    lo      = (n < (K+1)'(4)) ? '0 : (n >> 2);
    hi      = (n < (K+1)'(4)) ? (n - 1'b1) : (n - (n >> 2) - 1'b1);
    can_dec = WRAP || (win != '0);
    can_inc = WRAP || (w_end < B_L);
    if (cur_mode && neg) begin
      if (c_ext > lo)        c = c - 1'b1;
      else if (can_dec)      w = w - 1'b1;
      else if (c != '0)      c = c - 1'b1;
    end else if (cur_mode && pos) begin
      if (c_ext < hi)              c = c + 1'b1;
      else if (can_inc)            w = w + 1'b1;
      else if (c_ext < n - 1'b1)   c = c + 1'b1;
    end else if (neg && can_dec) begin
      w = w - 1'b1;
    end else if (pos && can_inc) begin
      w = w + 1'b1;
    end
    return {w, c};
  endfunction

  // Re-centre one axis on absolute cell a for new window side n2; returns {win, curs}.
  function automatic logic [2*K-1:0] f_zoom(input logic [K-1:0] a, input logic [K:0] n2);
    logic [K:0]   h, lim;
    logic [K-1:0] w;
    h   = n2 >> 1;
    lim = B_L - n2;
    if (WRAP)                        w = a - K'(h);
    else if ({1'b0, a} < h)          w = '0;
    else if ({1'b0, a} - h > lim)    w = K'(lim);
    else                             w = a - K'(h);
    return {w, a - w};
  endfunction

  auto_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_rep (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_tick      (tick),
    .i_dirs      ({wc_cmds.move_up, wc_cmds.move_down, wc_cmds.move_left, wc_cmds.move_right}),
    .o_step      (w_step),
    .o_err_multi (err_multi)
  );

  assign w_n        = (K+1)'(1) << r_zoom;
  assign w_half     = K'(w_n >> 1);
  assign w_absR     = r_winR + r_cursR;
  assign w_absC     = r_winC + r_cursC;
  assign w_run_rise = run_mode & ~r_run_q;
  assign w_cur_mode = ~wc_cmds.move_mode & ~run_mode;
  assign w_zin      = wc_cmds.zoom_in & ~wc_cmds.zoom_out & (r_zoom > ZW'(ZMIN));
  assign w_zout     = wc_cmds.zoom_out & ~wc_cmds.zoom_in & (r_zoom < ZW'(ZMAX));
  assign w_n2       = w_zin ? (w_n >> 1) : (w_n << 1);
  assign w_stepR    = f_step(r_winR, r_cursR, w_n, w_step[3], w_step[2], w_cur_mode);
  assign w_stepC    = f_step(r_winC, r_cursC, w_n, w_step[1], w_step[0], w_cur_mode);
  assign w_zoomR    = f_zoom(w_absR, w_n2);
  assign w_zoomC    = f_zoom(w_absC, w_n2);

  // Priority: run-mode entry recentre, then zoom, then a step
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_zoom  <= ZW'(INIT_ZOOM);
      r_winR  <= '0;
      r_winC  <= '0;
      r_cursR <= CURS_RST;
      r_cursC <= CURS_RST;
      r_run_q <= 1'b0;
    end else begin
      r_run_q <= run_mode;
      if (w_run_rise) begin
        r_cursR <= w_half;
        r_cursC <= w_half;
      end else if (w_zin || w_zout) begin
        r_zoom            <= w_zin ? (r_zoom - 1'b1) : (r_zoom + 1'b1);
        {r_winR, r_cursR} <= w_zoomR;
        {r_winC, r_cursC} <= w_zoomC;
      end else begin
        {r_winR, r_cursR} <= w_stepR;
        {r_winC, r_cursC} <= w_stepC;
      end
    end
  end

  assign zoom_lvl     = r_zoom;
  assign win_numCells = w_n;
  assign winR         = r_winR;
  assign winC         = r_winC;
  assign cursR        = r_cursR;
  assign cursC        = r_cursC;
  assign abs_cursR    = w_absR;
  assign abs_cursC    = w_absC;

endmodule

// File: tb/tb_win_curs_ctrl.sv
// Bench for win_curs_ctrl: directed scenarios plus randomized holds, zooms and
// run-mode toggles checked every cycle against a cell-level reference model.
module tb_win_curs_ctrl;
  import gol_pkg::*;

  localparam int K = 7, ZW = 3, ZMIN = 2, ZMAX = 6, INIT_ZOOM = 4, DLY = 16, PER = 4;
  localparam int B = 1 << K;
`ifdef WC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [3:0] D_UP = 4'b1000, D_DN = 4'b0100, D_LF = 4'b0010, D_RT = 4'b0001;

  logic          clk = 1'b0, rst_b = 1'b0, tick = 1'b0, run_mode = 1'b0;
  WC_CMDS        wc_cmds = '0;
  logic [ZW-1:0] zoom_lvl;
  logic [K:0]    win_numCells;
  logic [K-1:0]  winR, winC, cursR, cursC, abs_cursR, abs_cursC;
  logic          err_multi;

  win_curs_ctrl #(
    .K(K), .ZW(ZW), .ZMIN(ZMIN), .ZMAX(ZMAX), .INIT_ZOOM(INIT_ZOOM),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk), .rst_b(rst_b), .tick(tick), .run_mode(run_mode), .wc_cmds(wc_cmds),
    .zoom_lvl(zoom_lvl), .win_numCells(win_numCells), .winR(winR), .winC(winC),
    .cursR(cursR), .cursC(cursC), .abs_cursR(abs_cursR), .abs_cursC(abs_cursC),
    .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int m_zoom, m_winR, m_winC, m_cursR, m_cursC, m_err, m_prev_run, m_pdir, m_tcnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic WC_CMDS mk(input logic [3:0] d, input logic mode, input logic zi, input logic zo);
    return {d, mode, zi, zo};
  endfunction

  task automatic mdl_reset();
    m_zoom = INIT_ZOOM; m_winR = 0; m_winC = 0;
    m_cursR = (1 << INIT_ZOOM) / 2; m_cursC = (1 << INIT_ZOOM) / 2;
    m_err = 0; m_prev_run = 0; m_pdir = 0; m_tcnt = 0;
  endtask

  // sgn = -1 toward 0, +1 toward B-1
  task automatic mdl_move(inout int w, inout int c, input int n, input int sgn, input bit curmode);
    int lo, hi;
    bit inward, can_scroll, at_edge;
    lo = (n < 4) ? 0 : n / 4;
    hi = (n < 4) ? n - 1 : (3 * n) / 4 - 1;
    can_scroll = WRAP || ((sgn < 0) ? (w > 0) : (w + n < B));
    if (curmode) begin
      inward  = (sgn < 0) ? (c > lo) : (c < hi);
      at_edge = (sgn < 0) ? (c == 0) : (c == n - 1);
      if (inward)          c = c + sgn;
      else if (can_scroll) w = (w + sgn + B) % B;
      else if (!at_edge)   c = c + sgn;
    end else if (can_scroll) begin
      w = (w + sgn + B) % B;
    end
  endtask

  task automatic mdl_zoom(inout int w, inout int c, input int n2);
    int a;
    a = (w + c) % B;
    if (WRAP) begin
      w = (a - n2 / 2 + B) % B;
      c = n2 / 2;
    end else begin
      w = a - n2 / 2;
      if (w < 0) w = 0;
      if (w > B - n2) w = B - n2;
      c = a - w;
    end
  endtask

  task automatic mdl_clk(input WC_CMDS c, input logic tk, input logic rm);
    int held, dir, stepd, n;
    bit zin, zout, curmode;
    held = $countones({c.move_up, c.move_down, c.move_left, c.move_right});
    dir = 0;
    if (held == 1) dir = c.move_up ? 1 : c.move_down ? 2 : c.move_left ? 3 : 4;
    m_err = (held >= 2);
    stepd = 0;
    if (dir == 0) m_pdir = 0;
    else if (m_pdir != 0 && dir != m_pdir) m_pdir = 0;
    else if (m_pdir == 0) begin
      m_pdir = dir; m_tcnt = 0; stepd = dir;
    end else if (tk) begin
      m_tcnt++;
      if (m_tcnt == DLY || (m_tcnt > DLY && (m_tcnt - DLY) % PER == 0)) stepd = dir;
    end
    n    = 1 << m_zoom;
    zin  = c.zoom_in && !c.zoom_out && m_zoom > ZMIN;
    zout = c.zoom_out && !c.zoom_in && m_zoom < ZMAX;
    curmode = !c.move_mode && !rm;
    if (rm && !m_prev_run) begin
      m_cursR = n / 2; m_cursC = n / 2;
    end else if (zin || zout) begin
      m_zoom = zin ? m_zoom - 1 : m_zoom + 1;
      mdl_zoom(m_winR, m_cursR, 1 << m_zoom);
      mdl_zoom(m_winC, m_cursC, 1 << m_zoom);
    end else begin
      case (stepd)
        1: mdl_move(m_winR, m_cursR, n, -1, curmode);
        2: mdl_move(m_winR, m_cursR, n, 1, curmode);
        3: mdl_move(m_winC, m_cursC, n, -1, curmode);
        4: mdl_move(m_winC, m_cursC, n, 1, curmode);
        default: ;
      endcase
    end
    m_prev_run = rm;
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ".zoom"},  zoom_lvl,     m_zoom);
    chk({ctx, ".N"},     win_numCells, 1 << m_zoom);
    chk({ctx, ".winR"},  winR,         m_winR);
    chk({ctx, ".winC"},  winC,         m_winC);
    chk({ctx, ".cursR"}, cursR,        m_cursR);
    chk({ctx, ".cursC"}, cursC,        m_cursC);
    chk({ctx, ".absR"},  abs_cursR,    (m_winR + m_cursR) % B);
    chk({ctx, ".absC"},  abs_cursC,    (m_winC + m_cursC) % B);
    chk({ctx, ".err"},   err_multi,    m_err);
  endtask

  // Inputs change #1 after a rising edge; outputs sampled #1 after the next one
  task automatic cyc(input WC_CMDS c, input logic tk, input logic rm);
    wc_cmds = c; tick = tk; run_mode = rm;
    @(posedge clk);
    mdl_clk(c, tk, rm);
    #1 chk_all("cyc");
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #1 mdl_reset();
    chk_all("rst");
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    WC_CMDS idle_c;
    int r0, c0;
    bit rm_s;
    idle_c = '0;
    #12;
    mdl_reset();
    chk("rst_zoom", zoom_lvl, 4);
    chk("rst_N", win_numCells, 16);
    chk("rst_winR", winR, 0);
    chk("rst_winC", winC, 0);
    chk("rst_cursR", cursR, 8);
    chk("rst_cursC", cursC, 8);
    chk("rst_absR", abs_cursR, 8);
    chk("rst_absC", abs_cursC, 8);
    chk("rst_err", err_multi, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // Right taps: cursor walks to the margin then the window scrolls
    for (int i = 0; i < 4; i++) begin
      cyc(mk(D_RT, 0, 0, 0), 0, 0);
      if (i < 3) chk("tap_cursC", cursC, 9 + i);
      else begin
        chk("tap_winC", winC, 1);
        chk("tap_cursC_hold", cursC, 11);
        chk("tap_absC", abs_cursC, 12);
      end
      cyc(idle_c, 0, 0);
    end

    // Left taps at board edge: cursor enters the margin band down to 0
    do_reset();
    for (int i = 0; i < 4; i++) begin cyc(mk(D_LF, 0, 0, 0), 0, 0); cyc(idle_c, 0, 0); end
    chk("lf_start", cursC, 4);
    for (int i = 0; i < 5; i++) begin
      cyc(mk(D_LF, 0, 0, 0), 0, 0);
      chk("lf_cursC", cursC, (i < 4) ? 3 - i : 0);
      cyc(idle_c, 0, 0);
    end

    // Zoom keeps the cursor cell fixed; limits and simultaneous pulses ignored
    do_reset();
    cyc(mk(4'b0, 0, 1, 0), 0, 0);
    chk("zi_zoom", zoom_lvl, 3);
    chk("zi_N", win_numCells, 8);
    chk("zi_winR", winR, 4);
    chk("zi_winC", winC, 4);
    chk("zi_cursR", cursR, 4);
    chk("zi_cursC", cursC, 4);
    for (int i = 0; i < 3; i++) cyc(mk(4'b0, 0, 0, 1), 0, 0);
    chk("zo_max", zoom_lvl, 6);
    cyc(mk(4'b0, 0, 0, 1), 0, 0);
    chk("zo_clip", zoom_lvl, 6);
    chk("zo_clip_curs", cursR, 8);
    cyc(mk(4'b0, 0, 1, 1), 0, 0);
    chk("zboth", zoom_lvl, 6);
    cyc(idle_c, 0, 0);

    // Auto-repeat timing with a tick every 10 cycles
    do_reset();
    cyc(mk(D_RT, 0, 0, 0), 0, 0);
    chk("ar_press", cursC, 9);
    for (int t = 1; t <= 25; t++) begin
      repeat (9) cyc(mk(D_RT, 0, 0, 0), 0, 0);
      cyc(mk(D_RT, 0, 0, 0), 1, 0);
      if (t == 15) chk("ar_t15", cursC, 9);
      if (t == 16) chk("ar_t16", cursC, 10);
      if (t == 20) chk("ar_t20", cursC, 11);
      if (t == 24) begin chk("ar_t24_win", winC, 1); chk("ar_t24_curs", cursC, 11); end
    end
    cyc(idle_c, 1, 0);

    // Two directions held
    r0 = cursR; c0 = cursC;
    for (int i = 0; i < 3; i++) begin
      cyc(mk(D_UP | D_LF, 0, 0, 0), 1, 0);
      chk("multi_err", err_multi, 1);
      chk("multi_R", cursR, r0);
      chk("multi_C", cursC, c0);
    end
    cyc(idle_c, 0, 0);
    chk("multi_clr", err_multi, 0);

    // Entering run mode recentres the cursor
    do_reset();
    for (int i = 0; i < 5; i++) begin cyc(mk(D_UP, 0, 0, 0), 0, 0); cyc(idle_c, 0, 0); end
    for (int i = 0; i < 3; i++) begin cyc(mk(D_LF, 0, 0, 0), 0, 0); cyc(idle_c, 0, 0); end
    chk("run_preR", cursR, 3);
    chk("run_preC", cursC, 5);
    cyc(idle_c, 0, 1);
    chk("run_R", cursR, 8);
    chk("run_C", cursC, 8);
    chk("run_winR", winR, 0);
    cyc(idle_c, 0, 0);

    // Reset mid-hold; the held button counts as a fresh press afterwards
    do_reset();
    repeat (5) cyc(mk(D_RT, 0, 0, 0), 1, 0);
    do_reset();
    cyc(mk(D_RT, 0, 0, 0), 0, 0);
    chk("rsthold_C", cursC, 9);
    cyc(idle_c, 0, 0);

`ifdef WC_WRAP_EN
    do_reset();
    cyc(mk(D_LF, 1, 0, 0), 0, 0);
    chk("wrap_winC", winC, 127);
    cyc(idle_c, 0, 0);
`endif

    // Randomized hold segments with zooms, ticks and run-mode toggles
    do_reset();
    rm_s = 1'b0;
    for (int s = 0; s < 150; s++) begin
      logic [3:0] d;
      bit mode;
      int len, r;
      r    = $urandom_range(0, 9);
      d    = (r < 2) ? 4'b0000 : (r < 9) ? (D_RT << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      mode = ($urandom_range(0, 3) == 0);
      len  = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        bit zi, zo, tk;
        zi = ($urandom_range(0, 24) == 0);
        zo = ($urandom_range(0, 24) == 0);
        tk = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 99) == 0) rm_s = !rm_s;
        cyc(mk(d, mode, zi, zo), tk, rm_s);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/win_curs_ctrl.md
Name: win_curs_ctrl

Overview:
- Parametrised window/cursor controller for the Game of Life viewer.
- Tracks a power-of-two view window over a 2^K x 2^K board, a cursor relative to that window, and a zoom level.
- Direction buttons are held levels: an internal auto-repeat FSM turns them into step pulses.
- Zoom keeps the cursor's board cell fixed. Sits between the button debouncer and the display/cell-edit logic.

Parameters:
- K, 7: coordinate width; board side B = 2^K.
- ZW, 3: zoom-level width; must hold ZMAX.
- ZMIN, 2: minimum log2 window side.
- ZMAX, 6: maximum log2 window side, ZMAX <= K.
- INIT_ZOOM, 4: reset zoom level.
- REPEAT_DLY, 16: ticks from press to first repeat.
- REPEAT_PER, 4: ticks between subsequent repeats.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame strobe; clocks auto-repeat timing
- run_mode  in  1  1 = run, 0 = edit
- wc_cmds  in  WC_CMDS  held levels: move_up/down/left/right, move_mode (0 = cursor, 1 = window); one-cycle pulses: zoom_in, zoom_out
- zoom_lvl  out  ZW  current log2 window side
- win_numCells  out  K+1  N = 1 << zoom_lvl
- winR, winC  out  K  window origin
- cursR, cursC  out  K  cursor relative to window, in 0..N-1
- abs_cursR, abs_cursC  out  K  (win + curs) mod B, combinational from registers
- err_multi  out  1  registered; 1 for the cycle after more than one direction is held

Behaviour:
- Reset values: zoom_lvl = INIT_ZOOM; win = 0,0; curs = N/2, N/2; err_multi = 0; FSM in IDLE.
- Registered outputs update one cycle after the step or zoom event.
- Auto-repeat FSM, one shared instance:
  - IDLE: exactly one direction held -> emit step, clear counter, go to DELAY.
  - DELAY: count ticks. At REPEAT_DLY with the same direction still held -> step, clear counter, go to REPEAT.
  - REPEAT: step every REPEAT_PER ticks.
  - In any state, direction released or changed -> IDLE, no step.
  - Two or more directions held -> IDLE, no step, err_multi = 1.
- Step semantics. Margins lo = N/4, hi = 3N/4 - 1, both 0 and N-1 when N < 4.
  - Cursor mode, inward step (cursor inside the margins): cursor moves 1.
  - Cursor at margin, window can scroll: window moves 1, cursor held.
  - Cursor at margin, window at board edge (win = 0 or win + N = B): cursor moves toward 0 or N-1.
  - Cursor at absolute board edge: no change.
  - Window mode (move_mode = 1) or run_mode = 1: window moves 1 if within bounds, else no change; cursor relative held.
- Zoom, priority over a step in the same cycle:
  - zoom_in and zoom_out together: both ignored.
  - zoom_in below ZMIN or zoom_out above ZMAX: ignored.
  - Otherwise N' = N/2 or 2N; A = abs cursor. win' = clamp(A - N'/2, 0, B - N') per axis; curs' = A - win'.
- run_mode rising edge (flopped compare): curs = N/2, N/2; window unchanged; highest priority that cycle.
- Reset asserted mid-hold: FSM to IDLE. A held direction after reset release counts as a new press.

Optional Feature:
- WC_WRAP_EN defined: toroidal board. Window origin wraps mod B, with no clamping on move or zoom. A cursor at a margin always scrolls the window and never enters the margin band.
- Undefined: clamped behaviour as above.

Decomposition:
- gol_pkg holds: the WC_CMDS struct, a DIR_E enum (NONE, UP, DOWN, LEFT, RIGHT), and a REP_STATE_E enum (IDLE, DELAY, REPEAT).
- One sub-module, auto_repeat: held direction levels + tick in; one-hot step pulses + err_multi out.

Test Plan (K=7, B=128, ZMIN=2, ZMAX=6, INIT_ZOOM=4 so N=16):
- Reset -> zoom 4, N=16, win (0,0), curs (8,8), abs (8,8).
- Right held one cycle, repeated four times -> cursC 9, 10, 11, then winC 1 with cursC 11, abs_cursC 12.
- From win 0, curs 4, press left five times -> cursC 3, 2, 1, 0, 0.
- At abs (8,8): zoom_in -> N=8, win (4,4), curs (4,4). At zoom 6, zoom_out -> no change. zoom_in + zoom_out together -> no change.
- Right held with tick every 10 cycles -> steps at press, at tick 16, then ticks 20 and 24; release -> IDLE.
- Up+left held -> err_multi=1, no movement.
- run_mode 0->1 at curs (3,5) -> curs (8,8).
- WC_WRAP_EN: win (0,0) in window mode, press left -> winC 127.
